// File: rtl/alu_iter_muldiv.sv
// Registered EX-stage ALU with single-cycle ops and iterative unsigned multiply/divide.
// Operands are captured at start, and the outputs hold their values until the next op completes.
module alu_iter_muldiv #(
  parameter int WIDTH  = 32,
  parameter int DIV_EN = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic             ifNeedOf,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             sign,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_SLL  = 4'b0010, OP_OR   = 4'b0011,
    OP_AND  = 4'b0100, OP_ADDU = 4'b0101, OP_SLT  = 4'b0110, OP_XOR  = 4'b0111,
    OP_MULU = 4'b1000, OP_DIVU = 4'b1001, OP_REMU = 4'b1010
  } op_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi;
  logic             r_overflow;
  logic [SHW:0]     r_count;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic             r_is_mul;
  logic             r_is_rem;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_hi;
  logic             w_ov;
  logic             w_iter;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_rsh;
  logic             w_ge;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  assign w_sum    = A + B;
  assign w_dif    = A - B;
  assign w_accept = start && (r_state != S_ITER);
  assign w_last   = (r_state == S_ITER) && (r_count == CNT_ONE);

  always_comb begin
    w_res  = '0;
    w_hi   = '0;
    w_ov   = 1'b0;
    w_iter = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        w_res = w_sum;
        w_ov  = ifNeedOf && (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ov  = ifNeedOf && (A[WIDTH-1] != B[WIDTH-1]) && (w_dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL:  w_res = B << A[SHW-1:0];
      OP_OR:   w_res = A | B;
      OP_AND:  w_res = A & B;
      OP_ADDU: w_res = w_sum;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_XOR:  w_res = A ^ B;
      OP_MULU: w_iter = 1'b1;
      OP_DIVU, OP_REMU: begin
        if (DIV_EN != 0) begin
          if (B == '0) begin
            w_res = (ALUOp == OP_DIVU) ? '1 : A;
            w_hi  = A;
          end else begin
            w_iter = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Multiply: shift-add with the multiplier in r_lo; divide: restoring, dividend/quotient in r_lo.
  always_comb begin
    w_msum = {1'b0, r_acc} + {1'b0, r_opnd & {WIDTH{r_lo[0]}}};
    w_rsh  = {r_acc, r_lo[WIDTH-1]};
    w_ge   = (w_rsh >= {1'b0, r_opnd});
    if (r_is_mul) begin
      w_acc_nxt = w_msum[WIDTH:1];
      w_lo_nxt  = {w_msum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_acc_nxt = w_ge ? (w_rsh[WIDTH-1:0] - r_opnd) : w_rsh[WIDTH-1:0];
      w_lo_nxt  = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_iter ? S_ITER : S_DONE;
      S_ITER:  if (r_count == CNT_ONE) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? (w_iter ? S_ITER : S_DONE) : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_result   <= '0;
      r_hi       <= '0;
      r_overflow <= 1'b0;
      r_count    <= '0;
      r_acc      <= '0;
      r_lo       <= '0;
      r_opnd     <= '0;
      r_is_mul   <= 1'b0;
      r_is_rem   <= 1'b0;
    end else if (w_accept) begin
      if (w_iter) begin
        r_is_mul <= (ALUOp == OP_MULU);
        r_is_rem <= (ALUOp == OP_REMU);
        r_acc    <= '0;
        r_lo     <= (ALUOp == OP_MULU) ? B : A;
        r_opnd   <= (ALUOp == OP_MULU) ? A : B;
        r_count  <= CNT_INIT;
      end else begin
        r_result   <= w_res;
        r_hi       <= w_hi;
        r_overflow <= w_ov;
      end
    end else if (r_state == S_ITER) begin
      r_acc   <= w_acc_nxt;
      r_lo    <= w_lo_nxt;
      r_count <= r_count - CNT_ONE;
      if (w_last) begin
        r_result   <= r_is_rem ? w_acc_nxt : w_lo_nxt;
        r_hi       <= w_acc_nxt;
        r_overflow <= 1'b0;
      end
    end
  end

  assign result   = r_result;
  assign hi       = r_hi;
  assign overflow = r_overflow;
  assign sign     = r_result[WIDTH-1];
  assign zero     = (r_result == '0);
  assign busy     = (r_state == S_ITER);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_alu_iter_muldiv.sv
// Directed self-checking bench for alu_iter_muldiv at WIDTH=32 with hand-computed expectations.
module tb_alu_iter_muldiv;

  logic        CLK;
  logic        Reset;
  logic        start;
  logic [3:0]  ALUOp;
  logic        ifNeedOf;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic [31:0] hi;
  logic        sign;
  logic        zero;
  logic        overflow;
  logic        busy;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;
  int nb;
  logic saw_done;

  alu_iter_muldiv #(.WIDTH(32), .DIV_EN(1)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .ALUOp(ALUOp), .ifNeedOf(ifNeedOf),
    .A(A), .B(B), .result(result), .hi(hi), .sign(sign), .zero(zero),
    .overflow(overflow), .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with start dropped.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic of);
    ALUOp = op; A = a; B = b; ifNeedOf = of; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_iter(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge CLK);
    end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; ALUOp = 4'h0; ifNeedOf = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge CLK);
    check("rst_result", result, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_sign", {31'b0, sign}, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h1);
    check("rst_ovf", {31'b0, overflow}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    Reset = 1'b0;
    @(negedge CLK);

    issue(4'b0000, 32'h7FFFFFFF, 32'h00000001, 1'b1);
    check("add_ov_result", result, 32'h80000000);
    check("add_ov_ovf", {31'b0, overflow}, 32'h1);
    check("add_ov_sign", {31'b0, sign}, 32'h1);
    check("add_ov_done", {31'b0, done}, 32'h1);
    check("add_ov_hi", hi, 32'h0);

    issue(4'b0000, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    check("add_noen_ovf", {31'b0, overflow}, 32'h0);

    issue(4'b0001, 32'h0, 32'h0, 1'b1);
    check("sub0_result", result, 32'h0);
    check("sub0_zero", {31'b0, zero}, 32'h1);
    check("sub0_ovf", {31'b0, overflow}, 32'h0);

    issue(4'b0001, 32'h80000000, 32'h00000001, 1'b1);
    check("sub_ov_result", result, 32'h7FFFFFFF);
    check("sub_ov_ovf", {31'b0, overflow}, 32'h1);

    issue(4'b0110, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    check("slt_neg", result, 32'h1);
    issue(4'b0110, 32'h00000001, 32'hFFFFFFFF, 1'b0);
    check("slt_pos", result, 32'h0);
    issue(4'b0010, 32'h00000024, 32'h00000001, 1'b0);
    check("sll", result, 32'h00000010);

    issue(4'b0011, 32'hF0F00000, 32'h0FF0FF00, 1'b0);
    check("or", result, 32'hFFF0FF00);
    issue(4'b0100, 32'hF0F00000, 32'h0FF0FF00, 1'b0);
    check("and", result, 32'h00F00000);
    issue(4'b0111, 32'hF0F00000, 32'h0FF0FF00, 1'b0);
    check("xor", result, 32'hFF00FF00);
    issue(4'b0101, 32'h7FFFFFFF, 32'h00000001, 1'b1);
    check("addu_result", result, 32'h80000000);
    check("addu_ovf", {31'b0, overflow}, 32'h0);
    issue(4'b1011, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    check("undef_result", result, 32'h0);
    check("undef_done", {31'b0, done}, 32'h1);

    issue(4'b1000, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    wait_iter(nb);
    check("mulu_busy_cycles", nb, 32'd32);
    check("mulu_done", {31'b0, done}, 32'h1);
    check("mulu_result", result, 32'hFFFFFFFE);
    check("mulu_hi", hi, 32'h00000001);

    issue(4'b1001, 32'h00000100, 32'h00000007, 1'b0);
    wait_iter(nb);
    check("divu_busy_cycles", nb, 32'd32);
    check("divu_result", result, 32'h00000024);
    check("divu_hi", hi, 32'h00000004);

    issue(4'b1001, 32'h00000100, 32'h00000000, 1'b0);
    check("div0_done", {31'b0, done}, 32'h1);
    check("div0_result", result, 32'hFFFFFFFF);
    check("div0_hi", hi, 32'h00000100);

    issue(4'b1010, 32'h00000100, 32'h00000007, 1'b0);
    wait_iter(nb);
    check("remu_result", result, 32'h00000004);
    check("remu_hi", hi, 32'h00000004);

    // start during ITER must be ignored and operand changes must not disturb the product
    issue(4'b1000, 32'h12345678, 32'h00000010, 1'b0);
    nb = 0;
    while (busy === 1'b1 && nb < 100) begin
      nb++;
      if (nb == 5) begin
        check("hold_while_busy", result, 32'h00000004);
        ALUOp = 4'b0000; A = 32'h1; B = 32'h1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
    end
    start = 1'b0;
    check("inj_busy_cycles", nb, 32'd32);
    check("inj_result", result, 32'h23456780);
    check("inj_hi", hi, 32'h00000001);

    issue(4'b1000, 32'hFFFFFFFF, 32'h00000003, 1'b0);
    repeat (9) @(negedge CLK);
    check("pre_rst_busy", {31'b0, busy}, 32'h1);
    Reset = 1'b1;
    @(negedge CLK);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_result", result, 32'h0);
    check("midrst_zero", {31'b0, zero}, 32'h1);
    Reset = 1'b0;
    saw_done = done;
    repeat (40) begin
      @(negedge CLK);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", {31'b0, saw_done}, 32'h0);

    issue(4'b0000, 32'h00000001, 32'h00000002, 1'b0);
    check("b2b_first", result, 32'h00000003);
    ALUOp = 4'b0000; A = 32'h3; B = 32'h4; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("b2b_done", {31'b0, done}, 32'h1);
    check("b2b_result", result, 32'h00000007);
    @(negedge CLK);
    check("b2b_idle", {31'b0, done}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
